// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: receiver lock states and default 640x480@60 timing, shared with the vga generator.
package vga_rx_pkg;
    typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} rx_state_t;
    localparam int H_VIZ_DEF       = 640;
    localparam int H_PULSE_DEF     = 96;
    localparam int H_BP_DEF        = 48;
    localparam int H_FP_DEF        = 16;
    localparam int H_SYNC_DEF      = 800;
    localparam int V_VIZ_DEF       = 480;
    localparam int V_PULSE_DEF     = 2;
    localparam int V_BP_DEF        = 33;
    localparam int V_FP_DEF        = 10;
    localparam int V_SYNC_DEF      = 525;
    localparam int LOCK_FRAMES_DEF = 2;
    function automatic logic in_win(input logic [9:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction
endpackage

// File: rtl/vga_rx_edge.sv
// vga_rx_edge: registers an active-low sync input and flags its falling and rising edges.
module vga_rx_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sync,
    output logic o_fall,
    output logic o_rise
);
    logic r_s, r_p;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s <= 1'b1;
            r_p <= 1'b1;
        end else begin
            r_s <= i_sync;
            r_p <= r_s;
        end
    end
    assign o_fall = r_p & ~r_s;
    assign o_rise = ~r_p & r_s;
endmodule

// File: rtl/vga_rx.sv
// vga_rx: recovers pixel coordinates and data enable from hsync/vsync and tracks timing lock.
module vga_rx
    import vga_rx_pkg::*;
#(
    parameter int H_VIZ       = H_VIZ_DEF,
    parameter int H_PULSE     = H_PULSE_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int V_VIZ       = V_VIZ_DEF,
    parameter int V_PULSE     = V_PULSE_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic       clk_rx,
    input  logic       rst_rx,
    input  logic       h_in_rx,
    input  logic       v_in_rx,
    input  logic [7:0] color_in_rx,
    output logic [9:0] horizontal_x_rx,
    output logic [9:0] vertical_y_rx,
    output logic       de_rx,
    output logic [7:0] color_out_rx,
    output logic       locked_rx,
    output logic       err_rx
);
    localparam int H_ORG = H_PULSE + H_BP;
    localparam int V_ORG = V_PULSE + V_BP;
    // Never let the visible window spill into the front porch, even with inconsistent parameters.
    localparam int H_END = (H_ORG + H_VIZ < H_SYNC - H_FP) ? H_ORG + H_VIZ : H_SYNC - H_FP;
    localparam int V_END = (V_ORG + V_VIZ < V_SYNC - V_FP) ? V_ORG + V_VIZ : V_SYNC - V_FP;

    logic       w_h_fall, w_h_rise, w_v_fall, w_v_rise;
    logic [7:0] r_color;
    logic [9:0] r_h_cnt, r_v_cnt, w_h_cnt, w_v_cnt;
    logic       r_v_pend, r_h_seen, r_v_seen, w_v_load, w_viz, w_err;
    rx_state_t  r_state, w_state;
    logic [7:0] r_good, w_good;
    logic       r_de, r_err;
    logic [9:0] r_x, r_y;
    logic [7:0] r_col;

    vga_rx_edge u_h_edge (.i_clk(clk_rx), .i_rst(rst_rx), .i_sync(h_in_rx), .o_fall(w_h_fall), .o_rise(w_h_rise));
    vga_rx_edge u_v_edge (.i_clk(clk_rx), .i_rst(rst_rx), .i_sync(v_in_rx), .o_fall(w_v_fall), .o_rise(w_v_rise));

    // w_h_cnt/w_v_cnt are the coordinates of the pixel currently held in the input stage.
    always_comb begin
        w_h_cnt  = w_h_fall ? 10'd0 : (&r_h_cnt ? r_h_cnt : r_h_cnt + 10'd1);
        w_v_load = w_h_fall & (w_v_fall | r_v_pend);
        w_v_cnt  = w_v_load ? 10'd0 : (w_h_fall ? r_v_cnt + 10'd1 : r_v_cnt);
        w_err    = (w_h_fall & r_h_seen & (r_h_cnt != 10'(H_SYNC - 1)))
                 | (w_h_rise & r_h_seen & (w_h_cnt != 10'(H_PULSE)))
                 | (~w_h_fall & (r_h_cnt == 10'd1022))
                 | (w_v_load & r_v_seen & (r_v_cnt != 10'(V_SYNC - 1)))
                 | (w_v_rise & r_v_seen & (w_v_cnt != 10'(V_PULSE)));
        w_viz    = in_win(w_h_cnt, H_ORG, H_END) & in_win(w_v_cnt, V_ORG, V_END);
    end

    always_comb begin
        w_state = r_state;
        w_good  = r_good;
        if (w_err) begin
            w_state = SEARCH;
        end else if (w_v_load && r_state == SEARCH) begin
            w_state = ACQUIRE;
            w_good  = 8'd0;
        end else if (w_v_load && r_state == ACQUIRE) begin
            w_good  = r_good + 8'd1;
            w_state = (w_good == 8'(LOCK_FRAMES)) ? LOCKED : ACQUIRE;
        end
    end

    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            r_state  <= SEARCH;
            r_good   <= 8'd0;
            r_color  <= 8'd0;
            r_h_cnt  <= 10'd0;
            r_v_cnt  <= 10'd0;
            r_v_pend <= 1'b0;
            r_h_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_good   <= w_good;
            r_color  <= color_in_rx;
            r_h_cnt  <= w_h_cnt;
            r_v_cnt  <= w_v_cnt;
            r_v_pend <= ~w_v_load & (r_v_pend | w_v_fall);
            r_h_seen <= ~w_err & (r_h_seen | w_h_fall);
            r_v_seen <= ~w_err & (r_v_seen | w_v_load);
        end
    end

    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            r_de  <= 1'b0;
            r_x   <= 10'd0;
            r_y   <= 10'd0;
            r_col <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_de  <= w_viz & (r_state == LOCKED);
            r_x   <= w_viz ? w_h_cnt - 10'(H_ORG) : 10'd0;
            r_y   <= w_viz ? w_v_cnt - 10'(V_ORG) : 10'd0;
            r_col <= w_viz ? r_color : 8'd0;
            r_err <= w_err;
        end
    end

    assign horizontal_x_rx = r_x;
    assign vertical_y_rx   = r_y;
    assign de_rx           = r_de;
    assign color_out_rx    = r_col;
    assign locked_rx       = (r_state == LOCKED);
    assign err_rx          = r_err;
endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameter H_VIZ, 640, visible pixels per line.
REQ-002 Parameter H_PULSE, 96, hsync pulse width in clocks.
REQ-003 Parameter H_BP, 48; H_FP, 16; H_SYNC, 800, horizontal back porch, front porch and total clocks per line.
REQ-004 Parameter V_VIZ, 480; V_PULSE, 2; V_BP, 33; V_FP, 10; V_SYNC, 525, vertical equivalents in lines.
REQ-005 Parameter LOCK_FRAMES, 2, consecutive error-free frames required for lock.
REQ-006 clk_rx  in  1  single clock, pixel rate (25 MHz).
REQ-007 rst_rx  in  1  reset, asynchronous, active-high.
REQ-008 h_in_rx  in  1  hsync, active-low pulse.
REQ-009 v_in_rx  in  1  vsync, active-low pulse.
REQ-010 color_in_rx  in  8  pixel colour, valid during visible region.
REQ-011 horizontal_x_rx / vertical_y_rx  out  10 each  recovered pixel coordinate.
REQ-012 de_rx  out  1  data enable: locked and inside visible region.
REQ-013 color_out_rx  out  8  colour aligned with de_rx and coordinates.
REQ-014 locked_rx  out  1  timing lock; err_rx  out  1  one-cycle pulse per detected timing error.

Function
REQ-015 Stage 1 registers h_in_rx, v_in_rx, color_in_rx; all detection uses the registered values; hsync edge = previous registered 1, current 0 (vsync edge likewise).
REQ-016 h_cnt (10 bit) is 0 on the hsync-edge cycle, increments each clock, saturates at 1023.
REQ-017 v_cnt (10 bit) increments on each hsync edge; on the first hsync edge on or after a vsync edge (same-cycle included) it loads 0.
REQ-018 Visible region: h_cnt in [H_PULSE+H_BP, H_PULSE+H_BP+H_VIZ-1] and v_cnt in [V_PULSE+V_BP, V_PULSE+V_BP+V_VIZ-1].
REQ-019 x = h_cnt-(H_PULSE+H_BP), y = v_cnt-(V_PULSE+V_BP) inside visible region; outside, coordinates and color_out_rx are 0.
REQ-020 Outputs registered; total latency from input pins to de_rx/coords/color_out_rx is exactly 2 clocks.
REQ-021 de_rx is forced 0 unless state is LOCKED.
REQ-022 Errors: hsync edge with h_cnt != H_SYNC-1 (except first edge after SEARCH); hsync rising with h_cnt != H_PULSE; h_cnt reaching 1023; vsync-line load with v_cnt != V_SYNC-1 (except first); vsync pulse length != V_PULSE lines.
REQ-023 Each error raises err_rx for exactly one cycle, at most one pulse per cycle for simultaneous errors.
REQ-024 FSM states SEARCH, ACQUIRE, LOCKED; reset state SEARCH.
REQ-025 SEARCH -> ACQUIRE on first vsync-line load; good-frame counter cleared.
REQ-026 ACQUIRE: each error-free frame increments counter; at LOCK_FRAMES -> LOCKED.
REQ-027 Any error in ACQUIRE or LOCKED -> SEARCH next cycle; locked_rx falls same cycle as state change.
REQ-028 locked_rx = 1 only in LOCKED.

Reset
REQ-029 Asynchronous assertion clears all registers: counters 0, state SEARCH, pipeline registers 1 for sync, 0 for colour.
REQ-030 All outputs 0 during and after reset until driven by function; reset mid-frame discards lock, reacquisition restarts from SEARCH.

Structure
REQ-031 Shared package holds state enum and default timing constants, also used by vga.
REQ-032 One sub-module natural: vga_rx_edge (sync register plus falling/rising edge detect), instantiated for h and v.

Verification
REQ-033 Drive vga output into vga_rx, default params -> locked_rx rises at start of frame 3 (after 2 good frames), no err_rx.
REQ-034 Locked; first visible pixel (h_cnt=144, v_cnt=35) colour 0xA5 -> 2 clocks later de_rx=1, x=0, y=0, color_out_rx=0xA5.
REQ-035 Locked; one line shortened to 799 clocks -> single err_rx pulse, locked_rx 0 next cycle, relock after 2 clean frames.
REQ-036 Locked; hsync held high -> err_rx when h_cnt hits 1023, state SEARCH, de_rx 0.
REQ-037 Vsync and hsync edges same cycle -> v_cnt loads 0 that edge, no error.
REQ-038 rst_rx asserted mid-line while locked -> all outputs 0 immediately (asynchronous), relock after 2 frames post-release.
